pic_inta_sequencer: RTL and testbench

//  CPU-facing acknowledge controller of the 8259 PIC. It resolves the highest-priority

---
 rtl/pic_pkg.sv | 34 +++
 rtl/pic_priority_resolver.sv | 22 ++
 rtl/pic_inta_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style INTA sequencer.
//   state_t       : acknowledge FSM states
//   IR_W, IDX_W   : request vector width and encoded index width
//   SPURIOUS_IDX  : index reported when the request vanished before the first INTA
//   onehot / ffs  : index <-> one-hot helpers (ffs returns the lowest set bit, IR0 first)
package pic_pkg;

    localparam int IR_W  = 8;
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] SPURIOUS_IDX = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK1,
        WAIT2,
        ACK2
    } state_t;

    function automatic logic [IR_W-1:0] onehot(input logic [IDX_W-1:0] idx);
        return IR_W'(1) << idx;
    endfunction

    // Lowest set bit wins; returns 0 for an all-zero input (callers qualify with != 0).
    function automatic logic [IDX_W-1:0] ffs(input logic [IR_W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = IR_W - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Fully nested priority resolver (IR0 highest).
//   cand   in  8 : candidate requests (irr & ~imr, or isr_in for the EOI path)
//   isr_in in  8 : bits already in service; a candidate must outrank the lowest of them
//   valid  out 1 : an eligible candidate exists
//   idx    out 3 : index of the highest-priority candidate
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [IR_W-1:0]  cand,
    input  logic [IR_W-1:0]  isr_in,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] isr_idx;

    assign idx     = ffs(cand);
    assign isr_idx = ffs(isr_in);
    // Only a strictly higher priority (lower index) than the active service may interrupt.
    assign valid   = (cand != '0) && ((isr_in == '0) || (idx < isr_idx));

endmodule

// File: rtl/pic_inta_sequencer.sv
// CPU-facing acknowledge controller of the 8259 PIC (8086 two-pulse INTA).
// Optional feature macro: PIC_AUTO_EOI_EN (auto-EOI on the end of the INTA sequence).
//   clk, rst            : clock, asynchronous active-high reset
//   irr, imr, isr_in    : request, mask (1 = masked) and in-service registers
//   vector_base         : ICW2 T7..T3
//   inta_n              : CPU acknowledge, active-low, asynchronous to clk
//   eoi_cmd             : one-cycle non-specific EOI strobe
//   aeoi                : auto-EOI select (only honoured with PIC_AUTO_EOI_EN)
//   int_out             : interrupt to CPU
//   isr_set / eoi_clear : one-cycle one-hot set / clear pulses for the ISR
//   int_done            : one-cycle pulse at end of the INTA sequence
//   data_out, data_oe   : vector {vector_base, idx} and its bus enable
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int NUM_IR    = 8,
    parameter int INTA_SYNC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IR-1:0] irr,
    input  logic [NUM_IR-1:0] imr,
    input  logic [NUM_IR-1:0] isr_in,
    input  logic [4:0]        vector_base,
    input  logic              inta_n,
    input  logic              eoi_cmd,
    input  logic              aeoi,
    output logic              int_out,
    output logic [NUM_IR-1:0] isr_set,
    output logic              int_done,
    output logic [NUM_IR-1:0] eoi_clear,
    output logic [7:0]        data_out,
    output logic              data_oe
);

    // ---------------- inta_n synchronizer and edge detect ----------------
    // Flops preset to 1 so that reset never fabricates an acknowledge edge.
    logic [INTA_SYNC-1:0] sync_reg;
    logic                 inta_prev_reg;
    logic                 inta_sync;
    logic                 fall;
    logic                 rise;

    generate
        for (genvar gi = 0; gi < INTA_SYNC; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= inta_n;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign inta_sync = sync_reg[INTA_SYNC-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) inta_prev_reg <= 1'b1;
        else     inta_prev_reg <= inta_sync;
    end

    assign fall = inta_prev_reg & ~inta_sync;
    assign rise = ~inta_prev_reg & inta_sync;

    // ---------------- priority resolution ----------------
    logic             req_valid;
    logic [IDX_W-1:0] req_idx;
    logic             eoi_valid;
    logic [IDX_W-1:0] eoi_idx;
    logic [IR_W-1:0]  eoi_next;

    pic_priority_resolver u_req_resolver (
        .cand   (irr & ~imr),
        .isr_in (isr_in),
        .valid  (req_valid),
        .idx    (req_idx)
    );

    // Non-specific EOI retires the highest-priority in-service level.
    pic_priority_resolver u_eoi_resolver (
        .cand   (isr_in),
        .isr_in ('0),
        .valid  (eoi_valid),
        .idx    (eoi_idx)
    );

    assign eoi_next = (eoi_cmd && eoi_valid) ? onehot(eoi_idx) : '0;

    // ---------------- acknowledge FSM ----------------
    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             int_out_reg;
    logic [IR_W-1:0]  isr_set_reg;
    logic             int_done_reg;
    logic [IR_W-1:0]  eoi_clear_reg;
    logic [7:0]       data_out_reg;
    logic             data_oe_reg;
`ifdef PIC_AUTO_EOI_EN
    logic             spurious_reg;
`else
    logic             unused_aeoi;
    assign unused_aeoi = aeoi;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            int_out_reg   <= 1'b0;
            isr_set_reg   <= '0;
            int_done_reg  <= 1'b0;
            eoi_clear_reg <= '0;
            data_out_reg  <= '0;
            data_oe_reg   <= 1'b0;
`ifdef PIC_AUTO_EOI_EN
            spurious_reg  <= 1'b0;
`endif
        end else begin
            // Strobes default low; EOI clear is independent of the FSM.
            isr_set_reg   <= '0;
            int_done_reg  <= 1'b0;
            eoi_clear_reg <= eoi_next;

            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        state_reg   <= REQ;
                        int_out_reg <= 1'b1;
                    end
                end
                REQ: begin
                    // Losing eligibility here keeps INT raised; the CPU will still acknowledge.
                    if (fall) begin
                        state_reg   <= ACK1;
                        int_out_reg <= 1'b0;
                        if (req_valid) begin
                            idx_reg     <= req_idx;
                            isr_set_reg <= onehot(req_idx);
`ifdef PIC_AUTO_EOI_EN
                            spurious_reg <= 1'b0;
`endif
                        end else begin
                            idx_reg <= SPURIOUS_IDX;
`ifdef PIC_AUTO_EOI_EN
                            spurious_reg <= 1'b1;
`endif
                        end
                    end
                end
                ACK1: begin
                    data_oe_reg <= 1'b0;
                    if (rise) state_reg <= WAIT2;
                end
                WAIT2: begin
                    if (fall) begin
                        state_reg    <= ACK2;
                        data_out_reg <= {vector_base, idx_reg};
                        data_oe_reg  <= 1'b1;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        state_reg    <= IDLE;
                        data_oe_reg  <= 1'b0;
                        int_done_reg <= 1'b1;
`ifdef PIC_AUTO_EOI_EN
                        if (aeoi && !spurious_reg)
                            eoi_clear_reg <= eoi_next | onehot(idx_reg);
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign int_out   = int_out_reg;
    assign isr_set   = isr_set_reg;
    assign int_done  = int_done_reg;
    assign eoi_clear = eoi_clear_reg;
    assign data_out  = data_out_reg;
    assign data_oe   = data_oe_reg;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: table-driven INTA sequences plus
// hand-written corner sequences, with pulse outputs checked against expectation queues.
module tb_pic_inta_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] irr, imr, isr_in;
    logic [4:0] vector_base;
    logic       inta_n, eoi_cmd, aeoi;
    logic       int_out, int_done, data_oe;
    logic [7:0] isr_set, eoi_clear, data_out;

    pic_inta_sequencer #(.NUM_IR(8), .INTA_SYNC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .irr         (irr),
        .imr         (imr),
        .isr_in      (isr_in),
        .vector_base (vector_base),
        .inta_n      (inta_n),
        .eoi_cmd     (eoi_cmd),
        .aeoi        (aeoi),
        .int_out     (int_out),
        .isr_set     (isr_set),
        .int_done    (int_done),
        .eoi_clear   (eoi_clear),
        .data_out    (data_out),
        .data_oe     (data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] q_isr[$];
    logic [7:0] q_vec[$];
    logic [7:0] q_done[$];   // expected eoi_clear coincident with int_done
    logic [7:0] q_eoi[$];
    logic       prev_oe = 1'b0;

    typedef struct {
        logic [7:0] irr;
        logic [7:0] imr;
        logic [7:0] isr;
        logic [4:0] vb;
        logic       exp_int;
        logic [7:0] exp_isr;
        logic [7:0] exp_vec;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic unexpected(input string name, input logic [7:0] got);
        checks++;
        failures++;
        $display("FAIL %s got=%h want=none", name, got);
    endtask

    // One clock: sample at the falling edge and score any pulse outputs.
    task automatic tick();
        @(negedge clk);
        if (isr_set !== 8'h00) begin
            if (q_isr.size() == 0) unexpected("unexpected_isr_set", isr_set);
            else check("isr_set_pulse", isr_set, q_isr.pop_front());
        end
        if (data_oe === 1'b1 && prev_oe === 1'b0) begin
            if (q_vec.size() == 0) unexpected("unexpected_vector", data_out);
            else check("vector", data_out, q_vec.pop_front());
        end
        prev_oe = data_oe;
        if (int_done !== 1'b0) begin
            if (q_done.size() == 0) unexpected("unexpected_int_done", {7'd0, int_done});
            else check("done_eoi_clear", eoi_clear, q_done.pop_front());
        end
        if (eoi_clear !== 8'h00) begin
            if (q_eoi.size() == 0) unexpected("unexpected_eoi_clear", eoi_clear);
            else check("eoi_clear_pulse", eoi_clear, q_eoi.pop_front());
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Full two-pulse acknowledge; irr is dropped after the first pulse.
    task automatic inta_seq(input logic [7:0] exp_isr, input logic [7:0] exp_vec,
                            input logic [7:0] exp_aeoi);
        if (exp_isr != 8'h00) q_isr.push_back(exp_isr);
        q_vec.push_back(exp_vec);
        q_done.push_back(exp_aeoi);
        if (exp_aeoi != 8'h00) q_eoi.push_back(exp_aeoi);
        inta_n = 1'b0;
        ticks(3);
        check("isr_set_latency", isr_set, exp_isr);
        check("int_out_after_ack1", {7'd0, int_out}, 8'h00);
        tick();
        irr = 8'h00;
        inta_n = 1'b1;
        ticks(4);
        inta_n = 1'b0;
        ticks(4);
        check("data_oe_ack2", {7'd0, data_oe}, 8'h01);
        check("data_out_ack2", data_out, exp_vec);
        inta_n = 1'b1;
        ticks(4);
        check("data_oe_idle", {7'd0, data_oe}, 8'h00);
        check("data_out_hold", data_out, exp_vec);
    endtask

    initial begin
        tbl[0] = '{8'h04, 8'h00, 8'h00, 5'h08, 1'b1, 8'h04, 8'h42};
        tbl[1] = '{8'h81, 8'h01, 8'h00, 5'h08, 1'b1, 8'h80, 8'h47};
        tbl[2] = '{8'h08, 8'h00, 8'h02, 5'h08, 1'b0, 8'h00, 8'h00};
        tbl[3] = '{8'h01, 8'h00, 8'h02, 5'h08, 1'b1, 8'h01, 8'h40};
        tbl[4] = '{8'h30, 8'h10, 8'h00, 5'h1F, 1'b1, 8'h20, 8'hFD};
        tbl[5] = '{8'hF0, 8'h00, 8'h40, 5'h0A, 1'b1, 8'h10, 8'h54};
        tbl[6] = '{8'h40, 8'h00, 8'h40, 5'h08, 1'b0, 8'h00, 8'h00};
        tbl[7] = '{8'hFF, 8'hFF, 8'h00, 5'h08, 1'b0, 8'h00, 8'h00};

        rst = 1'b1;
        irr = 8'h00; imr = 8'h00; isr_in = 8'h00; vector_base = 5'h08;
        inta_n = 1'b1; eoi_cmd = 1'b0; aeoi = 1'b0;
        ticks(2);
        check("rst_int_out", {7'd0, int_out}, 8'h00);
        check("rst_isr_set", isr_set, 8'h00);
        check("rst_data_oe", {7'd0, data_oe}, 8'h00);
        check("rst_data_out", data_out, 8'h00);
        check("rst_eoi_clear", eoi_clear, 8'h00);
        check("rst_int_done", {7'd0, int_done}, 8'h00);
        rst = 1'b0;
        ticks(2);

        // Reset while INT is pending: int_out drops without a clock edge.
        irr = 8'h04;
        ticks(3);
        check("req_int_out", {7'd0, int_out}, 8'h01);
        #1 rst = 1'b1;
        #1 check("rst_async_int_out", {7'd0, int_out}, 8'h00);
        irr = 8'h00;
        ticks(2);
        rst = 1'b0;
        ticks(2);
        $display("seq reset_in_req done");

        // Reset during the second acknowledge: data_oe drops immediately.
        irr = 8'h04;
        ticks(3);
        q_isr.push_back(8'h04);
        q_vec.push_back(8'h42);
        inta_n = 1'b0;
        ticks(4);
        irr = 8'h00;
        inta_n = 1'b1;
        ticks(4);
        inta_n = 1'b0;
        ticks(4);
        check("pre_rst_data_oe", {7'd0, data_oe}, 8'h01);
        #1 rst = 1'b1;
        #1 check("rst_async_data_oe", {7'd0, data_oe}, 8'h00);
        check("rst_async_int_out2", {7'd0, int_out}, 8'h00);
        inta_n = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(2);
        $display("seq reset_in_ack2 done");

        for (int r = 0; r < 8; r++) begin
            irr = tbl[r].irr; imr = tbl[r].imr; isr_in = tbl[r].isr;
            vector_base = tbl[r].vb;
            ticks(3);
            check("int_out_row", {7'd0, int_out}, {7'd0, tbl[r].exp_int});
            if (tbl[r].exp_int) inta_seq(tbl[r].exp_isr, tbl[r].exp_vec, 8'h00);
            $display("row %0d irr=%h imr=%h isr=%h int=%0b isr_set=%h vec=%h",
                     r, tbl[r].irr, tbl[r].imr, tbl[r].isr, int_out, tbl[r].exp_isr, data_out);
            irr = 8'h00; imr = 8'h00; isr_in = 8'h00;
            ticks(2);
        end

        // Spurious: request withdrawn before the first acknowledge.
        vector_base = 5'h08;
        irr = 8'h04;
        ticks(3);
        irr = 8'h00;
        ticks(3);
        check("spurious_int_held", {7'd0, int_out}, 8'h01);
        inta_seq(8'h00, 8'h47, 8'h00);
        $display("seq spurious vec=%h", data_out);

        // Non-specific EOI.
        isr_in = 8'h28;
        q_eoi.push_back(8'h08);
        eoi_cmd = 1'b1;
        tick();
        eoi_cmd = 1'b0;
        ticks(3);
        isr_in = 8'h00;
        eoi_cmd = 1'b1;
        tick();
        eoi_cmd = 1'b0;
        tick();
        check("eoi_empty_isr", eoi_clear, 8'h00);
        ticks(2);
        $display("seq eoi done");

`ifdef PIC_AUTO_EOI_EN
        aeoi = 1'b1;
        irr = 8'h02;
        ticks(3);
        check("aeoi_int_out", {7'd0, int_out}, 8'h01);
        inta_seq(8'h02, 8'h41, 8'h02);
        aeoi = 1'b0;
        ticks(2);
        $display("seq auto_eoi done");
`endif

        check("q_isr_drained", 8'(q_isr.size()), 8'h00);
        check("q_vec_drained", 8'(q_vec.size()), 8'h00);
        check("q_done_drained", 8'(q_done.size()), 8'h00);
        check("q_eoi_drained", 8'(q_eoi.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
